// File: rtl/cpu_onchip_memtest_master.sv
// Avalon-MM memory test master: writes a pattern over a word range, reads it back and compares.
// Optional build macro CPU_MEMTEST_LFSR_EN selects a Galois LFSR pattern instead of seed + i.
module cpu_onchip_memtest_master #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam int unsigned DcW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

`ifdef CPU_MEMTEST_LFSR_EN
    // Bit 0 of the 0x80200003 tap word is the polynomial's constant term, i.e. the feedback
    // bit itself, so it is not an xor position in the shifted word.
    localparam logic [DATA_W-1:0] LfsrMask = DATA_W'(32'h8020_0002);

    function automatic logic [DATA_W-1:0] pat_start(input logic [DATA_W-1:0] s);
        return (s == '0) ? DATA_W'(1) : s;
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] x);
        return (x >> 1) ^ (x[0] ? LfsrMask : '0);
    endfunction
`else
    function automatic logic [DATA_W-1:0] pat_start(input logic [DATA_W-1:0] s);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] x);
        return x + DATA_W'(1);
    endfunction
`endif

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_t;

    state_t                               state;
    logic [ADDR_W-1:0]                    base;
    logic [CntW-1:0]                      len;
    logic [CntW-1:0]                      cnt;
    logic [DATA_W-1:0]                    pat0;
    logic [DATA_W-1:0]                    pat;
    logic [DcW-1:0]                       drain_cnt;
    logic [RD_LATENCY-1:0]                pipe_vld;
    logic [RD_LATENCY-1:0][ADDR_W-1:0]    pipe_addr;
    logic [RD_LATENCY-1:0][DATA_W-1:0]    pipe_exp;
    logic                                 mismatch;

    assign mismatch = pipe_vld[RD_LATENCY-1] &&
                      (avm_readdata != pipe_exp[RD_LATENCY-1]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= StIdle;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '1;
            base           <= '0;
            len            <= '0;
            cnt            <= '0;
            pat0           <= '0;
            pat            <= '0;
            drain_cnt      <= '0;
            pipe_vld       <= '0;
            pipe_addr      <= '0;
            pipe_exp       <= '0;
        end else begin
            // Reads also drive the expected word on writedata, so the pipe takes it from there.
            pipe_vld[0]  <= avm_chipselect & ~avm_write;
            pipe_addr[0] <= avm_address;
            pipe_exp[0]  <= avm_writedata;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
            end

            if (mismatch) begin
                if (err_count != '1) err_count <= err_count + CntW'(1);
                if (err_count == '0) begin
                    first_err_addr <= pipe_addr[RD_LATENCY-1];
                    first_err_data <= avm_readdata;
                end
            end

            done <= 1'b0;

            if (abort) begin
                state          <= StIdle;
                busy           <= 1'b0;
                avm_chipselect <= 1'b0;
                avm_write      <= 1'b0;
                pipe_vld       <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            base           <= base_addr;
                            len            <= length;
                            pat0           <= pat_start(seed);
                            err_count      <= '0;
                            first_err_addr <= '0;
                            first_err_data <= '0;
                            pass           <= 1'b0;
                            busy           <= 1'b1;
                            if (length == '0) begin
                                state <= StDone;
                            end else begin
                                state          <= StWrite;
                                avm_chipselect <= 1'b1;
                                avm_write      <= 1'b1;
                                avm_address    <= base_addr;
                                avm_writedata  <= pat_start(seed);
                                pat            <= pat_next(pat_start(seed));
                                cnt            <= CntW'(1);
                            end
                        end
                    end
                    StWrite: begin
                        if (cnt == len) begin
                            state         <= StRead;
                            avm_write     <= 1'b0;
                            avm_address   <= base;
                            avm_writedata <= pat0;
                            pat           <= pat_next(pat0);
                        end else begin
                            avm_address   <= avm_address + ADDR_W'(1);
                            avm_writedata <= pat;
                            pat           <= pat_next(pat);
                        end
                        cnt <= (cnt == len) ? CntW'(1) : cnt + CntW'(1);
                    end
                    StRead: begin
                        if (cnt == len) begin
                            state          <= StDrain;
                            avm_chipselect <= 1'b0;
                            drain_cnt      <= '0;
                        end else begin
                            avm_address   <= avm_address + ADDR_W'(1);
                            avm_writedata <= pat;
                            pat           <= pat_next(pat);
                            cnt           <= cnt + CntW'(1);
                        end
                    end
                    StDrain: begin
                        if (drain_cnt == DcW'(RD_LATENCY - 1)) state <= StDone;
                        else drain_cnt <= drain_cnt + DcW'(1);
                    end
                    StDone: begin
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_onchip_memtest_master.sv
// Bench for cpu_onchip_memtest_master: two instances (read latency 1 and 2) share a RAM model.
// Honours CPU_MEMTEST_LFSR_EN so the reference pattern matches the build.
module tb_cpu_onchip_memtest_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, abort;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic [31:0] seed;

    logic        busy1, done1, pass1, cs1, wr1;
    logic [12:0] err1;
    logic [11:0] faddr1, addr1;
    logic [31:0] fdata1, wdata1, rd1;
    logic [3:0]  be1;
    logic        busy2, done2, pass2, cs2, wr2;
    logic [12:0] err2;
    logic [11:0] faddr2, addr2;
    logic [31:0] fdata2, wdata2, rd2, rd2a;
    logic [3:0]  be2;

    cpu_onchip_memtest_master #(.ADDR_W(12), .DATA_W(32), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr),
        .length(length), .seed(seed), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(faddr1), .first_err_data(fdata1),
        .avm_address(addr1), .avm_chipselect(cs1), .avm_write(wr1), .avm_byteenable(be1),
        .avm_writedata(wdata1), .avm_readdata(rd1)
    );

    cpu_onchip_memtest_master #(.ADDR_W(12), .DATA_W(32), .RD_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base_addr(base_addr),
        .length(length), .seed(seed), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_addr(faddr2), .first_err_data(fdata2),
        .avm_address(addr2), .avm_chipselect(cs2), .avm_write(wr2), .avm_byteenable(be2),
        .avm_writedata(wdata2), .avm_readdata(rd2)
    );

    // Both instances issue identical traffic, so only instance 1 writes the shared RAM.
    logic [31:0] mem     [4096];
    logic [31:0] corrupt [4096];
    always @(posedge clk) begin
        if (cs1 && wr1) mem[addr1] <= wdata1;
        rd1  <= mem[addr1] ^ corrupt[addr1];
        rd2a <= mem[addr2] ^ corrupt[addr2];
        rd2  <= rd2a;
    end

    typedef struct {
        int          cyc;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } bus_t;
    bus_t busq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mpat(input logic [31:0] s, input int i);
        logic [31:0] x;
`ifdef CPU_MEMTEST_LFSR_EN
        x = (s == 32'h0) ? 32'h1 : s;
        for (int n = 0; n < i; n++) x = x[0] ? ((x >> 1) ^ 32'h8020_0002) : (x >> 1);
`else
        x = s + 32'(i);
`endif
        return x;
    endfunction

    task automatic clear_corrupt();
        for (int i = 0; i < 4096; i++) corrupt[i] = 32'h0;
    endtask

    task automatic run(input logic [11:0] b, input logic [12:0] l, input logic [31:0] s,
                       input int restart_k, output int c1, output int c2, output int nd,
                       output logic busy_k1);
        busq.delete();
        @(negedge clk);
        base_addr = b; length = l; seed = s; start = 1'b1;
        c1 = -1; c2 = -1; nd = 0; busy_k1 = 1'b0;
        for (int k = 1; k <= 2 * int'(l) + 20; k++) begin
            @(negedge clk);
            start = (k == restart_k);
            if (k == restart_k) begin
                base_addr = b + 12'h100; length = 13'd2; seed = ~s;
            end
            if (k == 1) busy_k1 = busy1;
            if (cs1) busq.push_back('{k, wr1, addr1, wdata1, be1});
            if (done1) begin
                nd++;
                if (c1 < 0) c1 = k;
            end
            if (done2 && c2 < 0) c2 = k;
        end
    endtask

    task automatic check_model(input string tag, input logic [11:0] b, input logic [12:0] l,
                               input logic [31:0] s, input int c1, input int c2, input int nd,
                               input logic busy_k1);
        int          e = 0;
        int          nbad = 0;
        logic [11:0] fa = 12'h0;
        logic [31:0] fd = 32'h0;
        logic [11:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = 12'(int'(b) + i);
            if (corrupt[a] != 32'h0) begin
                if (e == 0) begin
                    fa = a;
                    fd = mpat(s, i) ^ corrupt[a];
                end
                e++;
            end
        end
        chk({tag, " busy"}, busy_k1, 1);
        chk({tag, " done_cyc1"}, c1, (l == 0) ? 2 : 2 * int'(l) + 3);
        chk({tag, " done_cyc2"}, c2, (l == 0) ? 2 : 2 * int'(l) + 4);
        chk({tag, " done_pulses"}, nd, 1);
        chk({tag, " err1"}, err1, e);
        chk({tag, " faddr1"}, faddr1, fa);
        chk({tag, " fdata1"}, fdata1, fd);
        chk({tag, " pass1"}, pass1, e == 0);
        chk({tag, " err2"}, err2, e);
        chk({tag, " fdata2"}, fdata2, fd);
        chk({tag, " pass2"}, pass2, e == 0);
        chk({tag, " bus_len"}, busq.size(), 2 * int'(l));
        for (int j = 0; j < busq.size(); j++) begin
            int idx;
            idx = (j < int'(l)) ? j : j - int'(l);
            if (busq[j].cyc != j + 1 || busq[j].wr != (j < int'(l)) || busq[j].be != 4'hF ||
                busq[j].addr != 12'(int'(b) + idx) ||
                (busq[j].wr && busq[j].data != mpat(s, idx)))
                nbad++;
        end
        chk({tag, " bus_seq"}, nbad, 0);
    endtask

    typedef struct {
        logic [11:0] base;
        logic [12:0] len;
        logic [31:0] seed;
        logic [11:0] ca0, ca1;
        logic [31:0] cx0, cx1;
        int          exp_err;
        logic [11:0] exp_faddr;
        logic [31:0] exp_fdata;
        logic        exp_pass;
        int          exp_cyc1, exp_cyc2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          c1, c2, nd, n, dcount;
        logic        bk;
        logic [11:0] rb;
        logic [12:0] rl;
        logic [31:0] rs;

        vecs[0] = '{12'h010, 13'd16, 32'hA5A5_0000, 12'h0, 12'h0, 32'h0, 32'h0,
                    0, 12'h000, 32'h0, 1'b1, 35, 36};
        vecs[1] = '{12'h010, 13'd16, 32'hA5A5_0000, 12'h015, 12'h018, 32'h1, 32'h100,
                    2, 12'h015, 32'hA5A5_0004, 1'b0, 35, 36};
        vecs[2] = '{12'hFFE, 13'd4, 32'h1234_5678, 12'h0, 12'h0, 32'h0, 32'h0,
                    0, 12'h000, 32'h0, 1'b1, 11, 12};
        vecs[3] = '{12'h123, 13'd0, 32'hDEAD_BEEF, 12'h0, 12'h0, 32'h0, 32'h0,
                    0, 12'h000, 32'h0, 1'b1, 2, 2};
        vecs[4] = '{12'hFFE, 13'd4, 32'h0, 12'h000, 12'h0, 32'h8000_0000, 32'h0,
                    1, 12'h000, 32'h8000_0002, 1'b0, 11, 12};

        clear_corrupt();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy1, 0);
        chk("rst done", done1, 0);
        chk("rst cs", cs1, 0);
        chk("rst wr", wr1, 0);
        chk("rst err", err1, 0);
        chk("rst pass", pass1, 0);
        chk("rst addr", addr1, 0);
        chk("rst wdata", wdata1, 0);
        chk("rst be", be1, 4'hF);
        chk("rst faddr", faddr1, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 5; v++) begin
            clear_corrupt();
            if (vecs[v].cx0 != 0) corrupt[vecs[v].ca0] = vecs[v].cx0;
            if (vecs[v].cx1 != 0) corrupt[vecs[v].ca1] = vecs[v].cx1;
            run(vecs[v].base, vecs[v].len, vecs[v].seed, 0, c1, c2, nd, bk);
            chk($sformatf("vec%0d cyc1", v), c1, vecs[v].exp_cyc1);
            chk($sformatf("vec%0d cyc2", v), c2, vecs[v].exp_cyc2);
            chk($sformatf("vec%0d err", v), err1, vecs[v].exp_err);
            chk($sformatf("vec%0d faddr", v), faddr1, vecs[v].exp_faddr);
`ifndef CPU_MEMTEST_LFSR_EN
            chk($sformatf("vec%0d fdata", v), fdata1, vecs[v].exp_fdata);
`endif
            chk($sformatf("vec%0d pass", v), pass1, vecs[v].exp_pass);
            check_model($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].seed,
                        c1, c2, nd, bk);
        end

        // Randomised runs against the reference model.
        for (int r = 0; r < 10; r++) begin
            clear_corrupt();
            rb = 12'($urandom);
            rl = 13'($urandom_range(0, 40));
            rs = $urandom;
            n  = (rl == 0) ? 0 : $urandom_range(0, 3);
            for (int c = 0; c < n; c++)
                corrupt[12'(int'(rb) + $urandom_range(0, int'(rl) - 1))] = $urandom | 32'h1;
            run(rb, rl, rs, 0, c1, c2, nd, bk);
            check_model($sformatf("rand%0d", r), rb, rl, rs, c1, c2, nd, bk);
        end
        clear_corrupt();

        // Abort on the 5th write cycle.
        @(negedge clk);
        base_addr = 12'h100; length = 13'd16; seed = 32'h5555_0000; start = 1'b1;
        dcount = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 6) begin
                abort = 1'b0;
                chk("abort cs", cs1, 0);
                chk("abort busy1", busy1, 0);
                chk("abort busy2", busy2, 0);
                chk("abort err", err1, 0);
            end
            if (k == 5) begin
                chk("abort pre_wr", {cs1, wr1, addr1}, {1'b1, 1'b1, 12'h104});
                abort = 1'b1;
            end
            if (done1 || done2) dcount++;
        end
        chk("abort no_done", dcount, 0);

        // start and abort together: abort wins.
        @(negedge clk);
        base_addr = 12'h200; length = 13'd4; seed = 32'h1; start = 1'b1; abort = 1'b1;
        dcount = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (k == 1) chk("start_abort busy", {busy1, cs1}, 2'b00);
            if (done1) dcount++;
        end
        chk("start_abort no_done", dcount, 0);

        // A new start runs normally; a start pulsed while busy is ignored.
        run(12'h200, 13'd8, 32'hCAFE_0000, 3, c1, c2, nd, bk);
        check_model("restart", 12'h200, 13'd8, 32'hCAFE_0000, c1, c2, nd, bk);

        // Reset in the middle of a test.
        @(negedge clk);
        base_addr = 12'h300; length = 13'd10; seed = 32'h7; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst outs", {busy1, done1, cs1, wr1, pass1, err1},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0});
        chk("midrst bus", {addr1, wdata1, be1}, {12'h0, 32'h0, 4'hF});
        reset_n = 1'b1;
        @(negedge clk);

`ifdef CPU_MEMTEST_LFSR_EN
        run(12'h040, 13'd4, 32'h0, 0, c1, c2, nd, bk);
        check_model("lfsr", 12'h040, 13'd4, 32'h0, c1, c2, nd, bk);
        if (busq.size() < 2) chk("lfsr size", busq.size(), 8);
        else begin
            chk("lfsr w0", busq[0].data, 32'h0000_0001);
            chk("lfsr w1", busq[1].data, 32'h8020_0002);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
